mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 188 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit between a core and a byte-addressed big-endian RAM.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses raise err_o.
module mem_access_unit #(
    parameter int G = 18
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         req_i,
    input  logic         we_i,
    input  logic [1:0]   size_i,
    input  logic         unsigned_i,
    input  logic [G-1:0] addr_i,
    input  logic [31:0]  wdata_i,
    output logic         ready_o,
    output logic         done_o,
    output logic [31:0]  rdata_o,
    output logic         err_o,
    output logic [G-1:0] mem_addr_o,
    output logic [31:0]  mem_wdata_o,
    output logic         mem_en_o,
    input  logic [31:0]  mem_data_i
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WRITE,
        RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    state_t       state_q, state_d;
    logic         we_q, we_d;
    logic [1:0]   size_q, size_d;
    logic         uns_q, uns_d;
    logic [G-1:0] addr_q, addr_d;
    logic [31:0]  wdata_q, wdata_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         err_q, err_d;
    logic [23:0]  rmw_q, rmw_d;

    logic         misal;
    logic         bad;
    logic         word_st;
    logic [31:0]  ld_ext;
    logic [31:0]  merged;

    // Misalignment detection is only meaningful when trapping is enabled.
`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        misal = 1'b0;
        if (size_q == SZ_HALF && addr_q[0])
            misal = 1'b1;
        if (size_q == SZ_WORD && addr_q[1:0] != 2'b00)
            misal = 1'b1;
    end
`else
    always_comb begin
        misal = 1'b0;
    end
`endif

    // Decode of the latched request: error, word store, load extension, RMW merge.
    always_comb begin
        bad     = (size_q == SZ_RSVD) || misal;
        word_st = we_q && (size_q == SZ_WORD) && !bad;
        unique case (size_q)
            SZ_BYTE: ld_ext = {{24{~uns_q & mem_data_i[31]}}, mem_data_i[31:24]};
            SZ_HALF: ld_ext = {{16{~uns_q & mem_data_i[31]}}, mem_data_i[31:16]};
            default: ld_ext = mem_data_i;
        endcase
        if (size_q == SZ_BYTE)
            merged = {wdata_q[7:0], rmw_q[23:0]};
        else
            merged = {wdata_q[15:0], rmw_q[15:0]};
    end

    // State and request registers, synchronously reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            rmw_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            rmw_q   <= rmw_d;
        end
    end

    // Next-state logic: latch on accept, capture read data at end of ACCESS.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        rmw_d   = rmw_q;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    size_d  = size_i;
                    uns_d   = unsigned_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    err_d   = 1'b0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (bad) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else if (!we_q) begin
                    rdata_d = ld_ext;
                    state_d = RESP;
                end else if (size_q == SZ_WORD) begin
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    rmw_d   = mem_data_i[23:0];
                    state_d = WRITE;
                end
            end
            WRITE: begin
                rdata_d = '0;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from state; write enable is masked while reset is held
    // so an aborted WRITE never reaches the RAM's falling-edge write.
    always_comb begin
        ready_o     = (state_q == IDLE);
        done_o      = (state_q == RESP);
        err_o       = (state_q == RESP) && err_q;
        rdata_o     = rdata_q;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_en_o    = 1'b0;
        unique case (state_q)
            ACCESS: begin
                mem_addr_o = addr_q;
                if (word_st) begin
                    mem_wdata_o = wdata_q;
                    mem_en_o    = ~RST;
                end
            end
            WRITE: begin
                mem_addr_o  = addr_q;
                mem_wdata_o = merged;
                mem_en_o    = ~RST;
            end
            default: begin
                mem_addr_o = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a big-endian byte RAM model.
module tb_mem_access_unit;

    localparam int G = 18;
    localparam int RSZ = 1 << G;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         req_i = 1'b0;
    logic         we_i = 1'b0;
    logic [1:0]   size_i = 2'b00;
    logic         unsigned_i = 1'b0;
    logic [G-1:0] addr_i = '0;
    logic [31:0]  wdata_i = '0;
    logic         ready_o;
    logic         done_o;
    logic [31:0]  rdata_o;
    logic         err_o;
    logic [G-1:0] mem_addr_o;
    logic [31:0]  mem_wdata_o;
    logic         mem_en_o;
    logic [31:0]  mem_data_i;

    logic [7:0]   ram [RSZ];

    int checks = 0;
    int failures = 0;

    mem_access_unit #(.G(G)) dut (
        .CLK(CLK),
        .RST(RST),
        .req_i(req_i),
        .we_i(we_i),
        .size_i(size_i),
        .unsigned_i(unsigned_i),
        .addr_i(addr_i),
        .wdata_i(wdata_i),
        .ready_o(ready_o),
        .done_o(done_o),
        .rdata_o(rdata_o),
        .err_o(err_o),
        .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_en_o(mem_en_o),
        .mem_data_i(mem_data_i)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        logic [G-1:0] a1, a2, a3;
        a1 = mem_addr_o + 1;
        a2 = mem_addr_o + 2;
        a3 = mem_addr_o + 3;
        mem_data_i = {ram[mem_addr_o], ram[a1], ram[a2], ram[a3]};
    end

    always @(negedge CLK) begin
        if (mem_en_o === 1'b1) begin
            ram[mem_addr_o]          = mem_wdata_o[31:24];
            ram[G'(mem_addr_o + 1)]  = mem_wdata_o[23:16];
            ram[G'(mem_addr_o + 2)]  = mem_wdata_o[15:8];
            ram[G'(mem_addr_o + 3)]  = mem_wdata_o[7:0];
        end
    end

    function automatic logic [31:0] rw(input int a);
        return {ram[a], ram[a+1], ram[a+2], ram[a+3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic xfer(input logic we, input logic [1:0] sz, input logic un,
                        input logic [G-1:0] a, input logic [31:0] wd, input logic hold,
                        output int lat, output int en, output logic [31:0] rd,
                        output logic er);
        we_i = we;
        size_i = sz;
        unsigned_i = un;
        addr_i = a;
        wdata_i = wd;
        req_i = 1'b1;
        step();
        req_i = hold;
        addr_i = a + 4;
        lat = 1;
        en = 0;
        while (done_o !== 1'b1 && lat < 8) begin
            if (mem_en_o === 1'b1) en++;
            step();
            lat++;
        end
        if (done_o !== 1'b1)
            chk("done_timeout", {31'b0, done_o}, 32'h1);
        rd = rdata_o;
        er = err_o;
        step();
        req_i = 1'b0;
    endtask

    initial begin
        int lat, en;
        logic [31:0] rd;
        logic er;

        for (int i = 0; i < RSZ; i++) ram[i] = 8'h00;
        ram[16'h10] = 8'h80; ram[16'h11] = 8'h12;
        ram[16'h12] = 8'h34; ram[16'h13] = 8'h56;
        ram[16'h14] = 8'h00;
        ram[16'h20] = 8'h11; ram[16'h21] = 8'h22;
        ram[16'h22] = 8'h33; ram[16'h23] = 8'h44;

        RST = 1'b1;
        step();
        step();
        chk("rst_ready", {31'b0, ready_o}, 32'h1);
        chk("rst_done", {31'b0, done_o}, 32'h0);
        chk("rst_err", {31'b0, err_o}, 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_en", {31'b0, mem_en_o}, 32'h0);
        chk("rst_addr", 32'(mem_addr_o), 32'h0);
        chk("rst_wdata", mem_wdata_o, 32'h0);
        RST = 1'b0;
        step();

        xfer(1'b0, 2'b00, 1'b0, 'h10, 32'h0, 1'b0, lat, en, rd, er);
        chk("lb_lat", lat, 2);
        chk("lb_en", en, 0);
        chk("lb_rdata", rd, 32'hFFFFFF80);
        chk("lb_err", {31'b0, er}, 32'h0);
        chk("lb_hold", rdata_o, 32'hFFFFFF80);
        chk("lb_idle_done", {31'b0, done_o}, 32'h0);

        xfer(1'b0, 2'b00, 1'b1, 'h10, 32'h0, 1'b0, lat, en, rd, er);
        chk("lbu_rdata", rd, 32'h00000080);
        xfer(1'b0, 2'b01, 1'b1, 'h10, 32'h0, 1'b0, lat, en, rd, er);
        chk("lhu_rdata", rd, 32'h00008012);
        xfer(1'b0, 2'b01, 1'b0, 'h10, 32'h0, 1'b0, lat, en, rd, er);
        chk("lh_rdata", rd, 32'hFFFF8012);
        xfer(1'b0, 2'b10, 1'b0, 'h10, 32'h0, 1'b1, lat, en, rd, er);
        chk("lw_rdata", rd, 32'h80123456);
        chk("lw_lat", lat, 2);
        chk("resp_req_ignored", {31'b0, ready_o}, 32'h1);
        xfer(1'b0, 2'b00, 1'b0, 'h11, 32'h0, 1'b0, lat, en, rd, er);
        chk("lb11_rdata", rd, 32'h00000012);

        xfer(1'b1, 2'b00, 1'b0, 'h20, 32'h000000AB, 1'b0, lat, en, rd, er);
        chk("sb_lat", lat, 3);
        chk("sb_en", en, 1);
        chk("sb_rdata", rd, 32'h0);
        chk("sb_err", {31'b0, er}, 32'h0);
        chk("sb_ram", rw('h20), 32'hAB223344);

        xfer(1'b1, 2'b01, 1'b0, 'h20, 32'h1234CAFE, 1'b0, lat, en, rd, er);
        chk("sh_lat", lat, 3);
        chk("sh_ram", rw('h20), 32'hCAFE3344);

        xfer(1'b1, 2'b10, 1'b0, 'h24, 32'hDEADBEEF, 1'b0, lat, en, rd, er);
        chk("sw_lat", lat, 2);
        chk("sw_en", en, 1);
        chk("sw_ram", rw('h24), 32'hDEADBEEF);
        xfer(1'b0, 2'b10, 1'b0, 'h24, 32'h0, 1'b0, lat, en, rd, er);
        chk("lw24_rdata", rd, 32'hDEADBEEF);

        xfer(1'b1, 2'b11, 1'b0, 'h20, 32'h0, 1'b0, lat, en, rd, er);
        chk("rsv_err", {31'b0, er}, 32'h1);
        chk("rsv_en", en, 0);
        chk("rsv_lat", lat, 2);
        chk("rsv_ram", rw('h20), 32'hCAFE3344);

        xfer(1'b0, 2'b10, 1'b0, 'h11, 32'h0, 1'b0, lat, en, rd, er);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_err", {31'b0, er}, 32'h1);
        chk("mis_en", en, 0);
`else
        chk("mis_rdata", rd, 32'h12345600);
        chk("mis_err", {31'b0, er}, 32'h0);
`endif

        we_i = 1'b1;
        size_i = 2'b00;
        unsigned_i = 1'b0;
        addr_i = 'h20;
        wdata_i = 32'h00000055;
        req_i = 1'b1;
        step();
        req_i = 1'b0;
        chk("ab_access_addr", 32'(mem_addr_o), 32'h20);
        chk("ab_access_en", {31'b0, mem_en_o}, 32'h0);
        step();
        chk("ab_write_en", {31'b0, mem_en_o}, 32'h1);
        chk("ab_write_data", mem_wdata_o, 32'h55FE3344);
        RST = 1'b1;
        #1;
        chk("ab_rst_en", {31'b0, mem_en_o}, 32'h0);
        step();
        RST = 1'b0;
        chk("ab_ready", {31'b0, ready_o}, 32'h1);
        chk("ab_done", {31'b0, done_o}, 32'h0);
        step();
        chk("ab_done2", {31'b0, done_o}, 32'h0);
        chk("ab_ram", rw('h20), 32'hCAFE3344);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
